// File: rtl/rob_banked.sv
// Banked reorder buffer: NBANK uops per row, in-order row commit, branch kill/resolve
// by mask, and precise exceptions that commit the older part of the head row.
module rob_banked #(
  parameter int NBANK     = 4,
  parameter int WIDTH_TAG = 3,
  parameter int WIDTH_REG = 7,
  parameter int WIDTH_BRM = 4,
  parameter int NWB       = 2,
  parameter int WIDTH_IDX = WIDTH_TAG + $clog2(NBANK)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_dis_we,
  input  logic [31:0]                  i_dis_pc,
  input  logic [NBANK-1:0]             i_dis_valid,
  input  logic [NBANK*WIDTH_BRM-1:0]   i_dis_brm,
  input  logic [NBANK*WIDTH_REG-1:0]   i_dis_prd,
  output logic                         o_dis_ready,
  output logic [WIDTH_TAG-1:0]         o_dis_tag,
  input  logic [NWB-1:0]               i_wb_en,
  input  logic [NWB*WIDTH_IDX-1:0]     i_wb_idx,
  input  logic [NWB-1:0]               i_wb_exc,
  input  logic                         i_kill_en,
  input  logic [WIDTH_BRM-1:0]         i_kill_brm,
  input  logic                         i_brok_en,
  input  logic [WIDTH_BRM-1:0]         i_brok_brm,
  output logic                         o_com_en,
  output logic [NBANK-1:0]             o_com_mask,
  output logic [NBANK*WIDTH_REG-1:0]   o_com_prd,
  output logic                         o_exc_en,
  output logic [31:0]                  o_exc_pc
);

  localparam int DEPTH      = 2 ** WIDTH_TAG;
  localparam int WIDTH_BANK = $clog2(NBANK);

  logic [31:0]                         pc_q    [DEPTH];
  logic [31:0]                         pc_d    [DEPTH];
  logic [NBANK-1:0]                    valid_q [DEPTH];
  logic [NBANK-1:0]                    valid_d [DEPTH];
  logic [NBANK-1:0]                    busy_q  [DEPTH];
  logic [NBANK-1:0]                    busy_d  [DEPTH];
  logic [NBANK-1:0]                    exc_q   [DEPTH];
  logic [NBANK-1:0]                    exc_d   [DEPTH];
  logic [NBANK-1:0][WIDTH_BRM-1:0]     brm_q   [DEPTH];
  logic [NBANK-1:0][WIDTH_BRM-1:0]     brm_d   [DEPTH];
  logic [NBANK-1:0][WIDTH_REG-1:0]     prd_q   [DEPTH];
  logic [NBANK-1:0][WIDTH_REG-1:0]     prd_d   [DEPTH];
  logic [WIDTH_TAG-1:0]                head_q, head_d, tail_q, tail_d;
  logic [WIDTH_TAG:0]                  count_q, count_d;

  logic [NBANK-1:0]                    head_valid, head_exc_vec, low_mask;
  logic [WIDTH_BANK-1:0]               exc_bank;
  logic                                head_complete, head_has_exc;
  logic                                commit_row, flush, dis_fire;
  logic [WIDTH_BRM-1:0]                kill_bits, brok_bits;
  logic [NBANK-1:0][WIDTH_BRM-1:0]     dis_brm;
  logic [WIDTH_TAG-1:0]                wb_row  [NWB];
  logic [WIDTH_BANK-1:0]               wb_bank [NWB];

  genvar gi;
  generate
    for (gi = 0; gi < NWB; gi++) begin : g_wb_split
      assign wb_row[gi]  = i_wb_idx[gi*WIDTH_IDX+WIDTH_BANK +: WIDTH_TAG];
      assign wb_bank[gi] = i_wb_idx[gi*WIDTH_IDX +: WIDTH_BANK];
    end
  endgenerate

  assign o_dis_ready = (count_q != (WIDTH_TAG+1)'(DEPTH));
  assign o_dis_tag   = tail_q;
  assign dis_fire    = i_dis_we && o_dis_ready;
  assign kill_bits   = i_kill_en ? i_kill_brm : '0;
  assign brok_bits   = i_brok_en ? i_brok_brm : '0;
  assign dis_brm     = i_dis_brm;

  // Head-row evaluation drives every output; nothing here looks at inputs.
  always_comb begin
    head_valid    = valid_q[head_q];
    head_exc_vec  = valid_q[head_q] & exc_q[head_q];
    head_complete = (count_q != '0) && ((valid_q[head_q] & busy_q[head_q]) == '0);
    head_has_exc  = |head_exc_vec;
    exc_bank      = '0;
    for (int k = NBANK-1; k >= 0; k--) begin
      if (head_exc_vec[k]) exc_bank = WIDTH_BANK'(k);
    end
    low_mask = '0;
    for (int k = 0; k < NBANK; k++) begin
      if (WIDTH_BANK'(k) < exc_bank) low_mask[k] = 1'b1;
    end
    commit_row = head_complete && !head_has_exc;
    flush      = head_complete && head_has_exc;
    o_com_en   = head_complete && (!head_has_exc || exc_bank != '0);
    o_com_mask = '0;
    if (head_complete) o_com_mask = head_has_exc ? (head_valid & low_mask) : head_valid;
    o_exc_en = flush;
    o_exc_pc = '0;
    if (flush) o_exc_pc = pc_q[head_q] + {{(30-WIDTH_BANK){1'b0}}, exc_bank, 2'b00};
    o_com_prd = '0;
    for (int k = 0; k < NBANK; k++) begin
      if (o_com_mask[k]) o_com_prd[k*WIDTH_REG +: WIDTH_REG] = prd_q[head_q][k];
    end
  end

  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    exc_d   = exc_q;
    brm_d   = brm_q;
    prd_d   = prd_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + (WIDTH_TAG+1)'(dis_fire) - (WIDTH_TAG+1)'(commit_row);

    for (int p = 0; p < NWB; p++) begin
      if (i_wb_en[p] && valid_q[wb_row[p]][wb_bank[p]]) begin
        busy_d[wb_row[p]][wb_bank[p]] = 1'b0;
        exc_d[wb_row[p]][wb_bank[p]]  = exc_d[wb_row[p]][wb_bank[p]] | i_wb_exc[p];
      end
    end

    // Kill is applied after write-back so it wins on the same slot.
    for (int r = 0; r < DEPTH; r++) begin
      for (int k = 0; k < NBANK; k++) begin
        if (valid_q[r][k] && ((brm_q[r][k] & kill_bits) != '0)) begin
          valid_d[r][k] = 1'b0;
          busy_d[r][k]  = 1'b0;
        end
        brm_d[r][k] = brm_q[r][k] & ~brok_bits;
      end
    end

    if (commit_row) begin
      valid_d[head_q] = '0;
      busy_d[head_q]  = '0;
      exc_d[head_q]   = '0;
      head_d          = head_q + WIDTH_TAG'(1);
    end

    if (dis_fire) begin
      pc_d[tail_q]    = i_dis_pc;
      valid_d[tail_q] = i_dis_valid;
      busy_d[tail_q]  = i_dis_valid;
      exc_d[tail_q]   = '0;
      prd_d[tail_q]   = i_dis_prd;
      for (int k = 0; k < NBANK; k++) brm_d[tail_q][k] = dis_brm[k] & ~brok_bits;
      tail_d = tail_q + WIDTH_TAG'(1);
    end

    // Exception flush discards everything younger, including this cycle's dispatch.
    if (flush) begin
      for (int r = 0; r < DEPTH; r++) begin
        valid_d[r] = '0;
        busy_d[r]  = '0;
        exc_d[r]   = '0;
      end
      tail_d  = head_q;
      count_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int r = 0; r < DEPTH; r++) begin
        valid_q[r] <= '0;
        busy_q[r]  <= '0;
        exc_q[r]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      exc_q   <= exc_d;
    end
  end

  always_ff @(posedge i_clk) begin
    pc_q  <= pc_d;
    brm_q <= brm_d;
    prd_q <= prd_d;
  end

endmodule

// File: tb/tb_rob_banked.sv
// Randomized and directed bench for rob_banked against a queue-of-rows reference model.
module tb_rob_banked;
  localparam int NBANK = 4, WIDTH_TAG = 3, WIDTH_REG = 7, WIDTH_BRM = 4, NWB = 2;
  localparam int WIDTH_IDX = 5, DEPTH = 8;

  logic                       clk = 1'b0, rst_n = 1'b0;
  logic                       dis_we, dis_ready, kill_en, brok_en, com_en, exc_en;
  logic [31:0]                dis_pc, exc_pc;
  logic [NBANK-1:0]           dis_valid, com_mask;
  logic [NBANK*WIDTH_BRM-1:0] dis_brm;
  logic [NBANK*WIDTH_REG-1:0] dis_prd, com_prd;
  logic [WIDTH_TAG-1:0]       dis_tag;
  logic [NWB-1:0]             wb_en, wb_exc;
  logic [NWB*WIDTH_IDX-1:0]   wb_idx;
  logic [WIDTH_BRM-1:0]       kill_brm, brok_brm;

  rob_banked #(.NBANK(NBANK), .WIDTH_TAG(WIDTH_TAG), .WIDTH_REG(WIDTH_REG),
               .WIDTH_BRM(WIDTH_BRM), .NWB(NWB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dis_we(dis_we), .i_dis_pc(dis_pc),
    .i_dis_valid(dis_valid), .i_dis_brm(dis_brm), .i_dis_prd(dis_prd),
    .o_dis_ready(dis_ready), .o_dis_tag(dis_tag), .i_wb_en(wb_en), .i_wb_idx(wb_idx),
    .i_wb_exc(wb_exc), .i_kill_en(kill_en), .i_kill_brm(kill_brm), .i_brok_en(brok_en),
    .i_brok_brm(brok_brm), .o_com_en(com_en), .o_com_mask(com_mask), .o_com_prd(com_prd),
    .o_exc_en(exc_en), .o_exc_pc(exc_pc));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]                pc;
    logic [NBANK-1:0]           valid, done, exc;
    logic [NBANK*WIDTH_BRM-1:0] brm;
    logic [NBANK*WIDTH_REG-1:0] prd;
  } row_t;

  row_t rob[$];
  int   m_head, m_tail, n_checks, n_pass, cyc;
  logic                       exp_ready, exp_com_en, exp_exc_en;
  logic [WIDTH_TAG-1:0]       exp_tag;
  logic [NBANK-1:0]           exp_mask;
  logic [NBANK*WIDTH_REG-1:0] exp_prd;
  logic [31:0]                exp_exc_pc;
  bit                         m_pop, m_flush;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Expected outputs straight from the oldest row in the queue.
  task automatic model_outputs();
    exp_ready  = rob.size() < DEPTH;
    exp_tag    = m_tail[WIDTH_TAG-1:0];
    exp_com_en = 0; exp_exc_en = 0; exp_mask = '0; exp_prd = '0; exp_exc_pc = '0;
    m_pop = 0; m_flush = 0;
    if (rob.size() > 0) begin
      row_t r = rob[0];
      bit pending = 0;
      int first_exc = -1;
      for (int k = 0; k < NBANK; k++) begin
        if (r.valid[k] && !r.done[k]) pending = 1;
        if (first_exc < 0 && r.valid[k] && r.exc[k]) first_exc = k;
      end
      if (!pending) begin
        if (first_exc < 0) begin
          exp_com_en = 1; exp_mask = r.valid; m_pop = 1;
        end else begin
          exp_exc_en = 1; m_flush = 1;
          exp_exc_pc = r.pc + 32'(4 * first_exc);
          exp_com_en = (first_exc > 0);
          for (int k = 0; k < first_exc; k++) exp_mask[k] = r.valid[k];
        end
        for (int k = 0; k < NBANK; k++)
          if (exp_mask[k]) exp_prd[k*WIDTH_REG +: WIDTH_REG] = r.prd[k*WIDTH_REG +: WIDTH_REG];
      end
    end
  endtask

  task automatic model_update(input bit pop, input bit flush);
    bit dis = dis_we && (rob.size() < DEPTH);
    for (int p = 0; p < NWB; p++) begin
      if (wb_en[p]) begin
        int idx = int'(wb_idx[p*WIDTH_IDX +: WIDTH_IDX]);
        int bank = idx % NBANK;
        int pos = ((idx / NBANK) - m_head + DEPTH) % DEPTH;
        if (pos < rob.size()) begin
          row_t r = rob[pos];
          if (r.valid[bank]) begin
            r.done[bank] = 1'b1;
            if (wb_exc[p]) r.exc[bank] = 1'b1;
          end
          rob[pos] = r;
        end
      end
    end
    for (int i = 0; i < rob.size(); i++) begin
      row_t r = rob[i];
      for (int k = 0; k < NBANK; k++) begin
        if (kill_en && r.valid[k] && ((r.brm[k*WIDTH_BRM +: WIDTH_BRM] & kill_brm) != 0))
          r.valid[k] = 1'b0;
        if (brok_en) r.brm[k*WIDTH_BRM +: WIDTH_BRM] = r.brm[k*WIDTH_BRM +: WIDTH_BRM] & ~brok_brm;
      end
      rob[i] = r;
    end
    if (flush) begin
      rob.delete();
      m_tail = m_head;
      return;
    end
    if (pop) begin
      void'(rob.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    if (dis) begin
      row_t r;
      r.pc = dis_pc; r.valid = dis_valid; r.done = '0; r.exc = '0; r.prd = dis_prd;
      r.brm = dis_brm;
      if (brok_en)
        for (int k = 0; k < NBANK; k++) r.brm[k*WIDTH_BRM +: WIDTH_BRM] = dis_brm[k*WIDTH_BRM +: WIDTH_BRM] & ~brok_brm;
      rob.push_back(r);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic check_outputs();
    model_outputs();
    check_val("dis_ready", dis_ready, exp_ready);
    check_val("dis_tag", dis_tag, exp_tag);
    check_val("com_en", com_en, exp_com_en);
    check_val("com_mask", com_mask, exp_mask);
    check_val("com_prd", com_prd, exp_prd);
    check_val("exc_en", exc_en, exp_exc_en);
    check_val("exc_pc", exc_pc, exp_exc_pc);
  endtask

  task automatic idle();
    dis_we = 0; dis_pc = '0; dis_valid = '0; dis_brm = '0; dis_prd = '0;
    wb_en = '0; wb_idx = '0; wb_exc = '0;
    kill_en = 0; kill_brm = '0; brok_en = 0; brok_brm = '0;
  endtask

  task automatic step();
    model_outputs();
    @(posedge clk);
    model_update(m_pop, m_flush);
    #1;
    cyc++;
    $display("cyc %0d dis=%0b wb=%b kill=%0b brok=%0b -> rdy=%0b tag=%0d com=%0b mask=%b exc=%0b pc=%h",
             cyc, dis_we, wb_en, kill_en, brok_en, dis_ready, dis_tag, com_en, com_mask, exc_en, exc_pc);
    check_outputs();
    idle();
  endtask

  task automatic set_dis(input logic [31:0] pc, input logic [3:0] v,
                         input logic [15:0] brm, input logic [27:0] prd);
    dis_we = 1; dis_pc = pc; dis_valid = v; dis_brm = brm; dis_prd = prd;
  endtask

  task automatic set_wb(input int p, input int idx, input bit exc);
    wb_en[p] = 1'b1;
    wb_idx[p*WIDTH_IDX +: WIDTH_IDX] = WIDTH_IDX'(idx);
    wb_exc[p] = exc;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    rob.delete(); m_head = 0; m_tail = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    check_outputs();
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0;
    idle();

    // Basic dispatch, write-back, commit.
    do_reset();
    check_val("rst_ready", dis_ready, 1);
    check_val("rst_tag", dis_tag, 0);
    set_dis(32'h0, 4'hF, 16'h0, {7'd3, 7'd2, 7'd1, 7'd0}); step();
    check_val("first_tag", dis_tag, 1);
    set_wb(0, 0, 0); set_wb(1, 1, 0); step();
    set_wb(0, 2, 0); set_wb(1, 3, 0); step();
    check_val("basic_com_en", com_en, 1);
    check_val("basic_mask", com_mask, 4'b1111);
    check_val("basic_prd", com_prd, {7'd3, 7'd2, 7'd1, 7'd0});
    step();

    // Fill, refuse, wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_dis(32'(i * 16), 4'hF, 16'h0, 28'(i)); step();
    end
    check_val("full_ready", dis_ready, 0);
    set_dis(32'h900, 4'hF, 16'h0, 28'h1); step();
    check_val("full_tag", dis_tag, 0);
    set_wb(0, 0, 0); set_wb(1, 1, 0); step();
    set_wb(0, 2, 0); set_wb(1, 3, 0); set_dis(32'hA00, 4'hF, 16'h0, 28'h2); step();
    check_val("full_commit_refused_tag", dis_tag, 0);
    step();
    check_val("after_commit_ready", dis_ready, 1);
    set_dis(32'hB00, 4'hF, 16'h0, 28'h3); step();
    check_val("wrap_tag", dis_tag, 1);

    // Kill by mask.
    do_reset();
    set_dis(32'h0, 4'hF, {4'd8, 4'd4, 4'd2, 4'd1}, {7'd10, 7'd11, 7'd12, 7'd13}); step();
    kill_en = 1; kill_brm = 4'b0100; step();
    set_wb(0, 0, 0); set_wb(1, 1, 0); step();
    set_wb(0, 3, 0); step();
    check_val("kill_com_en", com_en, 1);
    check_val("kill_mask", com_mask, 4'b1011);
    step();

    // Precise exception with partial commit; dispatch in the flush cycle is dropped.
    set_dis(32'h100, 4'hF, 16'h0, {7'd20, 7'd21, 7'd22, 7'd23}); step();
    set_wb(0, 4, 0); set_wb(1, 5, 0); step();
    set_wb(0, 6, 1); set_wb(1, 7, 0); step();
    check_val("exc_en_dir", exc_en, 1);
    check_val("exc_pc_dir", exc_pc, 32'h108);
    check_val("exc_com_en", com_en, 1);
    check_val("exc_mask", com_mask, 4'b0011);
    set_dis(32'h200, 4'hF, 16'h0, 28'h5); step();
    check_val("flush_ready", dis_ready, 1);
    check_val("flush_com_en", com_en, 0);
    check_val("flush_tag", dis_tag, 1);

    // Brok clears the bit, including on same-cycle dispatch; a later kill on it is harmless.
    do_reset();
    set_dis(32'h300, 4'hF, 16'h1111, 28'h1); step();
    set_dis(32'h310, 4'hF, 16'h1111, 28'h2); step();
    set_dis(32'h320, 4'hF, 16'h1111, 28'h3); brok_en = 1; brok_brm = 4'b0001; step();
    kill_en = 1; kill_brm = 4'b0001; step();
    for (int i = 0; i < 6; i++) begin
      set_wb(0, 2 * i, 0); set_wb(1, 2 * i + 1, 0); step();
      if (i == 1) check_val("brok_mask", com_mask, 4'b1111);
    end
    repeat (3) step();

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(2) == 0) begin
        logic [15:0] b;
        b = 16'($urandom & $urandom & $urandom);
        set_dis($urandom & 32'hFFFF_FFFC, 4'($urandom), b, 28'($urandom));
      end
      for (int p = 0; p < NWB; p++) begin
        if ($urandom_range(3) != 0) begin
          int row = (rob.size() > 0) ? (m_head + $urandom_range(rob.size() - 1)) % DEPTH
                                     : $urandom_range(DEPTH - 1);
          set_wb(p, row * NBANK + $urandom_range(NBANK - 1), $urandom_range(19) == 0);
        end
      end
      if ($urandom_range(15) == 0) begin kill_en = 1; kill_brm = 4'(1 << $urandom_range(3)); end
      if ($urandom_range(7) == 0) begin brok_en = 1; brok_brm = 4'(1 << $urandom_range(3)); end
      step();
    end

    // Asynchronous reset with rows in flight.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_dis(32'(i * 16), 4'hF, 16'h0, 28'(i)); step();
    end
    set_wb(0, 0, 0); set_wb(1, 1, 0); step();
    set_wb(0, 2, 0); set_wb(1, 3, 0); step();
    check_val("pre_rst_com_en", com_en, 1);
    rst_n = 0;
    #1;
    check_val("async_rst_com_en", com_en, 0);
    check_val("async_rst_tag", dis_tag, 0);
    check_val("async_rst_ready", dis_ready, 1);
    rob.delete(); m_head = 0; m_tail = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    check_outputs();
    set_dis(32'h40, 4'hF, 16'h0, 28'h7); step();
    check_val("post_rst_tag", dis_tag, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
